phaselock_ck1x: RTL

Lock qualifier for the clk1x/clk2x phase detector. It runs in the clk1x domain, synchronises the detector's `phaseout`, and requires a stable sampled phase before it declares lock. It then holds lock with a small miss tolerance and counts lock-loss events. Its outputs gate the 1x↔2x data-transfer logic, which may only use `phsel` while `lock`=1.

---
 rtl/phaselock_pkg.sv | 15 +
 rtl/sync2_ck1x.sv | 30 +++
 rtl/phaselock_ck1x.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/phaselock_pkg.sv
// Shared definitions for the clk1x/clk2x phase-lock qualifier.
// Holds the qualifier FSM state encoding and the default lock/miss thresholds.
package phaselock_pkg;

  // Qualifier FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Default thresholds
  localparam int unsigned LOCK_CNT_DEF = 16;
  localparam int unsigned MISS_CNT_DEF = 2;

endpackage

// File: rtl/sync2_ck1x.sv
// Two-flop synchroniser into the clk1x domain.
// Ports:
//   clk1x   - 1x clock
//   rstq1x_ - asynchronous active-low reset, both flops clear to 0
//   d_i     - asynchronous input
//   q_o     - synchronised output (2 clk1x cycles latency)
module sync2_ck1x (
  input  logic clk1x,
  input  logic rstq1x_,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability settling chain
  always_ff @(posedge clk1x or negedge rstq1x_) begin
    if (!rstq1x_) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/phaselock_ck1x.sv
// Lock qualifier for the clk1x/clk2x phase detector.
// Synchronises the detector output, requires LOCK_CNT consecutive equal
// samples before declaring lock, tolerates up to MISS_CNT-1 consecutive
// mismatches while locked, and counts lock-loss events (saturating).
// Ports:
//   clk1x    - 1x clock
//   rstq1x_  - asynchronous active-low reset
//   phasein  - detector phaseout (clk2x domain)
//   enable   - qualifier enable (level)
//   clrcnt   - synchronous clear of losscnt (pulse)
//   lock     - phase qualified
//   phsel    - sampled phase captured at lock
//   lockchg  - one-cycle pulse on every lock edge
//   losscnt  - saturating lock-loss event count
module phaselock_ck1x
  import phaselock_pkg::*;
#(
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned MISS_CNT = MISS_CNT_DEF,
  parameter int unsigned CW       = 5,
  parameter int unsigned EW       = 8
) (
  input  logic          clk1x,
  input  logic          rstq1x_,
  input  logic          phasein,
  input  logic          enable,
  input  logic          clrcnt,
  output logic          lock,
  output logic          phsel,
  output logic          lockchg,
  output logic [EW-1:0] losscnt
);

  logic          ph_s;
  logic [1:0]    state_q, state_d;
  logic          ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic          phsel_q, phsel_d;
  logic          lockchg_q, lockchg_d;
  logic [EW-1:0] losscnt_q, losscnt_d;
  logic [EW-1:0] loss_base;
  logic          loss_c;
  logic          match;

  sync2_ck1x u_sync (
    .clk1x   (clk1x),
    .rstq1x_ (rstq1x_),
    .d_i     (phasein),
    .q_o     (ph_s)
  );

  assign match = (ph_s == ref_q);

  // State and output registers
  always_ff @(posedge clk1x or negedge rstq1x_) begin
    if (!rstq1x_) begin
      state_q   <= ST_IDLE;
      ref_q     <= 1'b0;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      phsel_q   <= 1'b0;
      lockchg_q <= 1'b0;
      losscnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      phsel_q   <= phsel_d;
      lockchg_q <= lockchg_d;
      losscnt_q <= losscnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    phsel_d   = phsel_q;
    lockchg_d = 1'b0;
    loss_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        // cnt==0 marks the first acquire cycle; a mismatch restarts the run
        if ((cnt_q == '0) || !match) begin
          ref_d = ph_s;
          cnt_d = CW'(1);
        end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
          state_d   = ST_LOCK;
          lock_d    = 1'b1;
          phsel_d   = ref_q;
          lockchg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOCK: begin
        if (!match) begin
          if (MISS_CNT == 1) begin
            loss_c = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (match) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MISS_CNT - 1)) begin
          loss_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loss: drop lock and reacquire from a fresh first cycle; phsel holds
    if (loss_c) begin
      state_d   = ST_ACQ;
      cnt_d     = '0;
      lock_d    = 1'b0;
      lockchg_d = 1'b1;
    end

    // Disable overrides everything and is not a loss event
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      lock_d    = 1'b0;
      lockchg_d = lock_q;
      loss_c    = 1'b0;
    end
  end

  // Loss counter: clear first, then count, saturating at all-ones
  always_comb begin
    loss_base = clrcnt ? '0 : losscnt_q;
    losscnt_d = loss_base;
    if (loss_c && (loss_base != {EW{1'b1}})) losscnt_d = loss_base + EW'(1);
  end

  assign lock    = lock_q;
  assign phsel   = phsel_q;
  assign lockchg = lockchg_q;
  assign losscnt = losscnt_q;

endmodule
